// File: rtl/clkdiv.sv
// Three-way clock divider for the sequential switch. Input 0 is the clock, input 1 re-aligns all
// dividers to the next input-0 rising edge, and input 2 mutes the divided outputs.
module clkdiv #(
  parameter int DIV1 = 2,
  parameter int DIV2 = 4,
  parameter int DIV3 = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic signed [15:0] sample_in0,
  input  logic signed [15:0] sample_in1,
  input  logic signed [15:0] sample_in2,
  input  logic signed [15:0] sample_in3,
  output logic signed [15:0] sample_out0,
  output logic signed [15:0] sample_out1,
  output logic signed [15:0] sample_out2,
  output logic signed [15:0] sample_out3
);

  localparam logic signed [15:0] SCH_HI = 16'sd8000;
  localparam logic signed [15:0] SCH_LO = 16'sd2000;
  localparam logic signed [15:0] OUT_HI = 16'sd20000;
  localparam logic signed [15:0] OUT_LO = 16'sd0;

  function automatic logic schmitt(input logic st, input logic signed [15:0] s);
    if (!st) return (s > SCH_HI);
    return !(s < SCH_LO);
  endfunction

  function automatic logic [6:0] advance(input logic [6:0] h, input int div);
    if (h == 7'(2 * div - 1)) return 7'd0;
    return h + 7'd1;
  endfunction

  function automatic logic signed [15:0] level_out(input logic on);
    return on ? OUT_HI : OUT_LO;
  endfunction

  logic       clk_hi, rst_hi, mute_hi, pending;
  logic [6:0] h1, h2, h3;

  logic       clk_nx, rst_nx, mute_nx, pend_nx;
  logic [6:0] h1_nx, h2_nx, h3_nx;
  logic       rise, fall, trig;
  logic signed [15:0] out0_nx, out1_nx, out2_nx, out3_nx;

  logic unused_in3;
  assign unused_in3 = ^sample_in3;

  always_comb begin
    clk_nx  = schmitt(clk_hi, sample_in0);
    rst_nx  = schmitt(rst_hi, sample_in1);
    mute_nx = schmitt(mute_hi, sample_in2);
    rise    = clk_nx & ~clk_hi;
    fall    = ~clk_nx & clk_hi;
    trig    = rst_nx & ~rst_hi;
    pend_nx = pending;
    h1_nx   = h1;
    h2_nx   = h2;
    h3_nx   = h3;
    // A rising edge always wins over a simultaneous trigger and completes any pending re-alignment.
    if (rise && (pending || trig)) begin
      h1_nx   = 7'd0;
      h2_nx   = 7'd0;
      h3_nx   = 7'd0;
      pend_nx = 1'b0;
    end else if ((rise || fall) && !pending && !trig) begin
      h1_nx = advance(h1, DIV1);
      h2_nx = advance(h2, DIV2);
      h3_nx = advance(h3, DIV3);
    end else if (trig) begin
      pend_nx = 1'b1;
    end
    out0_nx = level_out(clk_nx);
    out1_nx = level_out((h1_nx < 7'(DIV1)) && !pend_nx && !mute_nx);
    out2_nx = level_out((h2_nx < 7'(DIV2)) && !pend_nx && !mute_nx);
    out3_nx = level_out((h3_nx < 7'(DIV3)) && !pend_nx && !mute_nx);
  end

  // Single register stage: state and outputs advance only on valid strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_hi      <= 1'b0;
      rst_hi      <= 1'b0;
      mute_hi     <= 1'b0;
      pending     <= 1'b1;
      h1          <= 7'd0;
      h2          <= 7'd0;
      h3          <= 7'd0;
      sample_out0 <= OUT_LO;
      sample_out1 <= OUT_LO;
      sample_out2 <= OUT_LO;
      sample_out3 <= OUT_LO;
    end else if (sample_valid) begin
      clk_hi      <= clk_nx;
      rst_hi      <= rst_nx;
      mute_hi     <= mute_nx;
      pending     <= pend_nx;
      h1          <= h1_nx;
      h2          <= h2_nx;
      h3          <= h3_nx;
      sample_out0 <= out0_nx;
      sample_out1 <= out1_nx;
      sample_out2 <= out2_nx;
      sample_out3 <= out3_nx;
    end
  end

endmodule

// File: tb/tb_clkdiv.sv
// Scoreboard bench for clkdiv: the driver pushes the expected outputs for every clock, and a
// monitor pops and compares them half a cycle after the registering edge.
module tb_clkdiv;
  localparam int D1 = 2, D2 = 4, D3 = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample_valid = 1'b0;
  logic signed [15:0] sample_in0 = '0, sample_in1 = '0, sample_in2 = '0, sample_in3 = '0;
  logic signed [15:0] sample_out0, sample_out1, sample_out2, sample_out3;

  clkdiv #(.DIV1(D1), .DIV2(D2), .DIV3(D3)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .sample_in0(sample_in0), .sample_in1(sample_in1),
    .sample_in2(sample_in2), .sample_in3(sample_in3),
    .sample_out0(sample_out0), .sample_out1(sample_out1),
    .sample_out2(sample_out2), .sample_out3(sample_out3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [15:0] o0, o1, o2, o3;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  bit driver_done = 1'b0;

  // Reference state: edges counted since the last alignment rather than a wrapping counter.
  bit m_clk, m_rst, m_mute, m_pend;
  int m_e;
  exp_t m_out;

  function automatic logic signed [15:0] lvl(input bit on);
    return on ? 16'sd20000 : 16'sd0;
  endfunction

  function automatic bit div_high(input int e, input int d);
    return ((e / d) % 2) == 0;
  endfunction

  task automatic model(input bit v, input bit r,
                       input logic signed [15:0] a0, a1, a2);
    bit nc, nr, nm, rise, fall, trig;
    if (r) begin
      m_clk = 0; m_rst = 0; m_mute = 0; m_pend = 1; m_e = 0;
      m_out = '0;
    end else if (v) begin
      nc = m_clk ? (a0 >= 16'sd2000) : (a0 > 16'sd8000);
      nr = m_rst ? (a1 >= 16'sd2000) : (a1 > 16'sd8000);
      nm = m_mute ? (a2 >= 16'sd2000) : (a2 > 16'sd8000);
      rise = nc && !m_clk;
      fall = !nc && m_clk;
      trig = nr && !m_rst;
      if (rise && (m_pend || trig)) begin
        m_e = 0; m_pend = 0;
      end else if (rise || fall) begin
        if (!m_pend && !trig) m_e++;
        if (trig) m_pend = 1;
      end else if (trig) begin
        m_pend = 1;
      end
      m_clk = nc; m_rst = nr; m_mute = nm;
      m_out.o0 = lvl(nc);
      m_out.o1 = lvl(!m_pend && !nm && div_high(m_e, D1));
      m_out.o2 = lvl(!m_pend && !nm && div_high(m_e, D2));
      m_out.o3 = lvl(!m_pend && !nm && div_high(m_e, D3));
    end
  endtask

  // One clock of stimulus; expected values are pushed once the DUT has registered them.
  task automatic step(input bit v, input bit r,
                      input logic signed [15:0] a0, a1, a2);
    sample_valid = v;
    rst = r;
    sample_in0 = a0;
    sample_in1 = a1;
    sample_in2 = a2;
    sample_in3 = 16'($urandom);
    @(posedge clk);
    model(v, r, a0, a1, a2);
    sb.push_back(m_out);
    #1;
  endtask

  task automatic square(input int periods, input logic signed [15:0] a1, a2);
    for (int p = 0; p < periods; p++) begin
      for (int k = 0; k < 4; k++) step(1, 0, 16'sd0, a1, a2);
      for (int k = 0; k < 4; k++) step(1, 0, 16'sd20000, a1, a2);
    end
  endtask

  task automatic check(input string name, input logic signed [15:0] act, exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out0", sample_out0, e.o0);
        check("out1", sample_out1, e.o1);
        check("out2", sample_out2, e.o2);
        check("out3", sample_out3, e.o3);
      end
    end
  end

  initial begin : driver
    @(posedge clk); #1;
    step(0, 1, 16'sd0, 16'sd0, 16'sd0);
    step(0, 1, 16'sd0, 16'sd0, 16'sd0);
    // Square wave, first rise aligns every divider
    square(16, 16'sd0, 16'sd0);
    // Hysteresis: mid-band holds, 1999 falls, 2000 and 8000 hold, 8001 rises
    step(1, 0, 16'sd5000, 16'sd0, 16'sd0);
    step(1, 0, 16'sd5000, 16'sd0, 16'sd0);
    step(1, 0, 16'sd1999, 16'sd0, 16'sd0);
    step(1, 0, 16'sd2000, 16'sd0, 16'sd0);
    step(1, 0, 16'sd8000, 16'sd0, 16'sd0);
    step(1, 0, 16'sd8001, 16'sd0, 16'sd0);
    step(1, 0, 16'sd2000, 16'sd0, 16'sd0);
    step(1, 0, -16'sd20000, 16'sd0, 16'sd0);
    square(3, 16'sd0, 16'sd0);
    // Reset-trigger pulse mid high phase, then re-alignment on the next rise
    step(1, 0, 16'sd20000, 16'sd10000, 16'sd0);
    step(1, 0, 16'sd20000, 16'sd10000, 16'sd0);
    step(1, 0, 16'sd0, 16'sd0, 16'sd0);
    step(1, 0, 16'sd0, 16'sd0, 16'sd0);
    square(4, 16'sd0, 16'sd0);
    // Trigger and input-0 rise in the same strobe
    step(1, 0, 16'sd0, 16'sd0, 16'sd0);
    step(1, 0, 16'sd20000, 16'sd20000, 16'sd0);
    step(1, 0, 16'sd20000, 16'sd20000, 16'sd0);
    step(1, 0, 16'sd0, 16'sd0, 16'sd0);
    square(2, 16'sd0, 16'sd0);
    // Mute for ten input periods
    square(10, 16'sd0, 16'sd10000);
    square(4, 16'sd0, 16'sd0);
    // Strobes idle while input 0 toggles: nothing may move
    for (int k = 0; k < 50; k++) step(0, 0, (k % 2) ? 16'sd20000 : 16'sd0, 16'sd10000, 16'sd10000);
    square(2, 16'sd0, 16'sd0);
    // Reset mid-run, then pending until the next rise
    step(1, 0, 16'sd20000, 16'sd0, 16'sd0);
    step(1, 1, 16'sd20000, 16'sd0, 16'sd0);
    step(1, 0, 16'sd20000, 16'sd0, 16'sd0);
    step(1, 0, 16'sd0, 16'sd0, 16'sd0);
    square(6, 16'sd0, 16'sd0);
    step(0, 0, 16'sd0, 16'sd0, 16'sd0);
    driver_done = 1'b1;
  end

  initial begin : finisher
    fork
      begin
        wait (driver_done);
        repeat (3) @(posedge clk);
      end
      begin
        #200000;
        total++;
        bad++;
        $display("FAIL timeout: driver_done=%0d expected 1", driver_done);
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
